// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix engine: RAM geometry defaults, requester
// IDs and the RAM arbiter state encoding.
package matrix_pkg;

  localparam int DATA_W    = 32;
  localparam int RAM_D     = 512;
  localparam int RAM_ADD_W = $clog2(RAM_D);

  localparam int REQ_HOST = 0;
  localparam int REQ_CU   = 1;
  localparam int REQ_WB   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer (wrapping) wins, returned one-hot together with an any-request flag.
module rr_priority_picker #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             any
);

  logic found;

  // Scan from the pointer; the first hit latches found and masks later hits.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      int  idx;
      logic hit;
      idx = int'(ptr) + k;
      idx = (idx >= N) ? (idx - N) : idx;
      hit = !found && req[idx[PTR_W-1:0]];
      winner[idx[PTR_W-1:0]] = winner[idx[PTR_W-1:0]] | hit;
      found = found | hit;
    end
  end

  assign any = |req;

endmodule

// File: rtl/matrix_ram_arbiter.sv
// Burst-granting round-robin arbiter for the single-port matrix RAM. Every RAM
// access is registered; read data returns to its issuing requester 2 cycles later.
module matrix_ram_arbiter
  import matrix_pkg::*;
#(
  parameter int DATA_W    = matrix_pkg::DATA_W,
  parameter int RAM_D     = matrix_pkg::RAM_D,
  parameter int RAM_ADD_W = $clog2(RAM_D),
  parameter int N_REQ     = 3,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*RAM_ADD_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_we,
  output logic [RAM_ADD_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]         ram_w_data,
  input  logic [DATA_W-1:0]         ram_r_data,
  output logic                      busy
);

  localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [OWN_W-1:0] LAST_REQ = OWN_W'(N_REQ - 1);

  arb_state_e         state_r, state_n;
  logic [OWN_W-1:0]   owner_r, owner_n;
  logic [OWN_W-1:0]   rr_ptr_r, rr_ptr_n;
  logic [CNT_W-1:0]   cnt_r, cnt_n, cnt_after_s;
  logic [N_REQ-1:0]   gnt_n;

  logic [N_REQ-1:0]   pick_onehot_s;
  logic               pick_any_s;
  logic [OWN_W-1:0]   pick_idx_s;

  logic               own_req_s, own_lock_s, own_we_s;
  logic [RAM_ADD_W-1:0] own_addr_s;
  logic [DATA_W-1:0]  own_wdata_s;
  logic               beat_s, others_s, leave_s;

  logic               rd_v1_r;
  logic [OWN_W-1:0]   rd_tag1_r;
  logic [N_REQ-1:0]   rvalid_n;

  rr_priority_picker #(
    .N     (N_REQ),
    .PTR_W (OWN_W)
  ) u_picker (
    .req    (req),
    .ptr    (rr_ptr_r),
    .winner (pick_onehot_s),
    .any    (pick_any_s)
  );

  // Encode the one-hot winner into an owner index.
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_idx_s = pick_idx_s | (OWN_W'(i) & {OWN_W{pick_onehot_s[i]}});
    end
  end

  assign own_req_s   = req[owner_r];
  assign own_lock_s  = lock[owner_r];
  assign own_we_s    = we[owner_r];
  assign own_addr_s  = addr[owner_r*RAM_ADD_W +: RAM_ADD_W];
  assign own_wdata_s = wdata[owner_r*DATA_W +: DATA_W];

  assign beat_s   = (state_r == OWN) && own_req_s && gnt[owner_r];
  assign others_s = |(req & ~gnt);

  // Beat count including this cycle's beat; frozen under lock, saturating.
  always_comb begin
    if (own_lock_s || !beat_s) begin
      cnt_after_s = cnt_r;
    end else if (cnt_r == CNT_MAX) begin
      cnt_after_s = cnt_r;
    end else begin
      cnt_after_s = cnt_r + CNT_W'(1);
    end
  end

  // Burst ends after the beat that reaches MAX_BURST, so a limited burst is exactly MAX_BURST beats.
  assign leave_s = !own_lock_s && (!own_req_s || ((cnt_after_s == CNT_MAX) && others_s));

  // Next-state, grant, owner, counter and pointer logic.
  always_comb begin
    state_n  = state_r;
    owner_n  = owner_r;
    rr_ptr_n = rr_ptr_r;
    cnt_n    = cnt_r;
    gnt_n    = gnt;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_n = OWN;
          owner_n = pick_idx_s;
          gnt_n   = pick_onehot_s;
          cnt_n   = '0;
        end else begin
          gnt_n = '0;
        end
      end
      OWN: begin
        cnt_n = cnt_after_s;
        if (leave_s) begin
          state_n = TURN;
          gnt_n   = '0;
        end else begin
          state_n = OWN;
        end
      end
      TURN: begin
        state_n  = IDLE;
        gnt_n    = '0;
        rr_ptr_n = (owner_r == LAST_REQ) ? '0 : (owner_r + OWN_W'(1));
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
      cnt_r    <= '0;
      gnt      <= '0;
    end else begin
      state_r  <= state_n;
      owner_r  <= owner_n;
      rr_ptr_r <= rr_ptr_n;
      cnt_r    <= cnt_n;
      gnt      <= gnt_n;
    end
  end

  // Second tag stage decodes the issuing owner of the read returning this cycle.
  always_comb begin
    rvalid_n = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rvalid_n[i] = rd_v1_r && (rd_tag1_r == OWN_W'(i));
    end
  end

  // Registered RAM access plus the owner-id tag pipeline for reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_w_data <= '0;
      rd_v1_r    <= 1'b0;
      rd_tag1_r  <= '0;
      rvalid     <= '0;
    end else begin
      ram_we    <= beat_s && own_we_s;
      rd_v1_r   <= beat_s && !own_we_s;
      rd_tag1_r <= owner_r;
      rvalid    <= rvalid_n;
      if (beat_s) begin
        ram_addr   <= own_addr_s;
        ram_w_data <= own_wdata_s;
      end
    end
  end

  assign rdata = (|rvalid) ? ram_r_data : '0;
  assign busy  = (state_r != IDLE) || rd_v1_r || (|rvalid);

endmodule

// File: tb/tb_matrix_ram_arbiter.sv
// Directed bench for matrix_ram_arbiter with a 1-cycle-latency RAM model;
// expected values are hand-derived cycle by cycle.
module tb_matrix_ram_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req, lock, we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_w_data;
  logic [DW-1:0] ram_r_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [512];

  matrix_ram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lock       (lock),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_w_data (ram_w_data),
    .ram_r_data (ram_r_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // RAM model: registered read, write on ram_we, pattern fill on reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      ram_r_data <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_w_data;
      ram_r_data <= mem[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int i, input logic w, input int a, input logic [DW-1:0] d);
    we[i] = w;
    addr[i*AW +: AW] = AW'(a);
    wdata[i*DW +: DW] = d;
  endtask

  int run_idx, run_len, gap;
  logic [2:0] cur;
  logic [2:0] run_own [4];
  int run_lens [4];
  int gaps [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) tick();
    check_eq("rst_gnt", 32'(gnt), 32'(3'b000));
    check_eq("rst_busy", 32'(busy), 32'(1'b0));
    check_eq("rst_ram_addr", 32'(ram_addr), 32'(9'd0));
    check_eq("rst_rdata", rdata, 32'h0);
    rst = 1'b1;
    tick();

    // 1. reset mid-burst
    req = 3'b001; set_beat(0, 1'b1, 5, 32'h1111_0005);
    tick();
    check_eq("t1_gnt_host", 32'(gnt), 32'(3'b001));
    tick();
    check_eq("t1_we_pre", 32'(ram_we), 32'(1'b1));
    check_eq("t1_addr_pre", 32'(ram_addr), 32'(9'd5));
    #2 rst = 1'b0;
    #1;
    check_eq("t1_async_gnt", 32'(gnt), 32'(3'b000));
    check_eq("t1_async_we", 32'(ram_we), 32'(1'b0));
    check_eq("t1_async_addr", 32'(ram_addr), 32'(9'd0));
    check_eq("t1_async_wdata", ram_w_data, 32'h0);
    check_eq("t1_async_busy", 32'(busy), 32'(1'b0));
    check_eq("t1_async_rvalid", 32'(rvalid), 32'(3'b000));
    req = '0;
    tick();
    rst = 1'b1;
    req = 3'b010; set_beat(1, 1'b0, 2, 32'h0);
    check_eq("t1_gnt_before_edge", 32'(gnt), 32'(3'b000));
    tick();
    check_eq("t1_gnt_cu", 32'(gnt), 32'(3'b010));

    // 2. back-to-back reads 2,3,4
    tick();
    check_eq("t2_addr2", 32'(ram_addr), 32'(9'd2));
    check_eq("t2_we0", 32'(ram_we), 32'(1'b0));
    check_eq("t2_rv_none", 32'(rvalid), 32'(3'b000));
    set_beat(1, 1'b0, 3, 32'h0);
    tick();
    check_eq("t2_addr3", 32'(ram_addr), 32'(9'd3));
    check_eq("t2_rv_a2", 32'(rvalid), 32'(3'b010));
    check_eq("t2_rd_a2", rdata, init_word(2));
    set_beat(1, 1'b0, 4, 32'h0);
    tick();
    check_eq("t2_addr4", 32'(ram_addr), 32'(9'd4));
    check_eq("t2_rv_a3", 32'(rvalid), 32'(3'b010));
    check_eq("t2_rd_a3", rdata, init_word(3));
    req = '0;
    tick();
    check_eq("t2_rv_a4", 32'(rvalid), 32'(3'b010));
    check_eq("t2_rd_a4", rdata, init_word(4));
    tick();
    check_eq("t2_rv_done", 32'(rvalid), 32'(3'b000));
    repeat (3) tick();
    check_eq("t2_idle_busy", 32'(busy), 32'(1'b0));

    // 3. round robin with all requesters, restart pointer from 0
    rst = 1'b0; tick(); rst = 1'b1; tick();
    set_beat(0, 1'b1, 20, 32'h0000_0020);
    set_beat(1, 1'b1, 40, 32'h0000_0040);
    set_beat(2, 1'b1, 60, 32'h0000_0060);
    req = 3'b111;
    run_idx = 0; run_len = 0; gap = 0; cur = '0;
    for (int c = 0; c < 100 && run_idx < 4; c++) begin
      tick();
      if (gnt != 3'b000) begin
        if (cur == 3'b000) begin
          run_own[run_idx] = gnt;
          gaps[run_idx] = gap;
          gap = 0;
        end
        run_len++;
        cur = gnt;
      end else begin
        if (cur != 3'b000) begin
          run_lens[run_idx] = run_len;
          run_idx++;
          run_len = 0;
          cur = '0;
        end
        gap++;
      end
    end
    req = '0;
    check_eq("t3_runs_seen", 32'(run_idx), 32'd4);
    if (run_idx == 4) begin
      check_eq("t3_own0", 32'(run_own[0]), 32'(3'b001));
      check_eq("t3_own1", 32'(run_own[1]), 32'(3'b010));
      check_eq("t3_own2", 32'(run_own[2]), 32'(3'b100));
      check_eq("t3_own3", 32'(run_own[3]), 32'(3'b001));
      for (int k = 0; k < 4; k++) check_eq($sformatf("t3_len%0d", k), 32'(run_lens[k]), 32'd8);
      // gap = TURN cycle plus the IDLE arbitration cycle
      for (int k = 1; k < 4; k++) check_eq($sformatf("t3_gap%0d", k), 32'(gaps[k]), 32'd2);
    end
    repeat (4) tick();

    // 4. locked host burst of 20 writes while WB waits (pointer now at CU)
    req = 3'b001; lock = 3'b001; set_beat(0, 1'b1, 100, 32'hC0DE_0000);
    tick();
    check_eq("t4_gnt_host", 32'(gnt), 32'(3'b001));
    req = 3'b101; set_beat(2, 1'b1, 300, 32'h0000_0300);
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq($sformatf("t4_gnt_%0d", k), 32'(gnt), 32'(3'b001));
      check_eq($sformatf("t4_we_%0d", k), 32'(ram_we), 32'(1'b1));
      check_eq($sformatf("t4_addr_%0d", k), 32'(ram_addr), 32'(100 + k));
      check_eq($sformatf("t4_wd_%0d", k), ram_w_data, 32'hC0DE_0000 + 32'(k));
      set_beat(0, 1'b1, 101 + k, 32'hC0DE_0000 + 32'(k + 1));
    end

    // 5. hold with lock and no requests, then writes at the top of the RAM
    req = 3'b100;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("t5_hold_gnt_%0d", k), 32'(gnt), 32'(3'b001));
      check_eq($sformatf("t5_hold_we_%0d", k), 32'(ram_we), 32'(1'b0));
      check_eq($sformatf("t5_hold_rv_%0d", k), 32'(rvalid), 32'(3'b000));
    end
    req = 3'b101; set_beat(0, 1'b1, 510, 32'hDEAD_01FE);
    tick();
    check_eq("t5_we510", 32'(ram_we), 32'(1'b1));
    check_eq("t5_addr510", 32'(ram_addr), 32'(9'd510));
    check_eq("t5_wd510", ram_w_data, 32'hDEAD_01FE);
    set_beat(0, 1'b1, 511, 32'hBEEF_01FF);
    tick();
    check_eq("t5_we511", 32'(ram_we), 32'(1'b1));
    check_eq("t5_addr511", 32'(ram_addr), 32'(9'd511));
    check_eq("t5_wd511", ram_w_data, 32'hBEEF_01FF);
    req = 3'b100; lock = 3'b000;
    tick();
    check_eq("t4_release_gnt", 32'(gnt), 32'(3'b000));
    check_eq("t4_release_we", 32'(ram_we), 32'(1'b0));
    tick();
    check_eq("t4_turn_gnt", 32'(gnt), 32'(3'b000));
    tick();
    check_eq("t4_gnt_wb", 32'(gnt), 32'(3'b100));
    req = '0;
    repeat (4) tick();
    check_eq("t4_idle_busy", 32'(busy), 32'(1'b0));

    // 6. read handover: CU read in flight completes after its grant is gone
    set_beat(1, 1'b0, 7, 32'h0);
    set_beat(2, 1'b0, 511, 32'h0);
    req = 3'b110;
    tick();
    check_eq("t6_gnt_cu", 32'(gnt), 32'(3'b010));
    tick();
    req = 3'b100;
    check_eq("t6_busy_inflight", 32'(busy), 32'(1'b1));
    tick();
    check_eq("t6_rv_cu", 32'(rvalid), 32'(3'b010));
    check_eq("t6_rd_cu", rdata, init_word(7));
    check_eq("t6_gnt_left_cu", 32'(gnt), 32'(3'b000));
    tick();
    check_eq("t6_rv_gap", 32'(rvalid), 32'(3'b000));
    tick();
    check_eq("t6_gnt_wb", 32'(gnt), 32'(3'b100));
    check_eq("t6_rv_wb_early", 32'(rvalid), 32'(3'b000));
    tick();
    req = '0;
    check_eq("t6_rv_wb_lat1", 32'(rvalid), 32'(3'b000));
    tick();
    check_eq("t6_rv_wb", 32'(rvalid), 32'(3'b100));
    check_eq("t6_rd_wb", rdata, 32'hBEEF_01FF);
    tick();
    check_eq("t6_rv_end", 32'(rvalid), 32'(3'b000));
    repeat (3) tick();
    check_eq("t6_final_busy", 32'(busy), 32'(1'b0));
    check_eq("t6_final_gnt", 32'(gnt), 32'(3'b000));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
